// File: rtl/spi_reg_pkg.sv
// Shared types and constants for the SPI register-bank initiator.
package spi_reg_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_CMD  = 3'd1;
  localparam state_t S_DATA = 3'd2;
  localparam state_t S_ACC  = 3'd3;
  localparam state_t S_DONE = 3'd4;

  localparam int unsigned CMD_WR_BIT = 7;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned CNT_W      = $clog2(BYTE_W);

endpackage

// File: rtl/spi_sync.sv
// Multi-stage synchroniser with registered rise/fall edge strobes (used for SPI clock).
module spi_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_o <= sync_q[STAGES-1] & ~prev_q;
      fall_o <= ~sync_q[STAGES-1] & prev_q;
    end
  end

endmodule

// File: rtl/spi_reg_initiator.sv
// SPI mode-0 peripheral that turns {wr_rdn,addr} + data frames into register-bank accesses.
// Define SPI_REG_AUTOINC_EN for burst mode (address auto-increment while CS stays low).
module spi_reg_initiator
  import spi_reg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 7,
  parameter int unsigned REG_W       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned ACK_TIMEOUT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              spi_cs_n,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              wr_rdn,
  output logic [ADDR_W-1:0] addr,
  output logic [REG_W-1:0]  wdata,
  output logic              req,
  output logic              we,
  input  logic [REG_W-1:0]  rdata,
  input  logic              ack,
  input  logic              err,
  output logic              xfer_err
);

  localparam int unsigned TMR_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
`ifdef SPI_REG_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic [SYNC_STAGES-1:0] cs_sync_q, mosi_sync_q;
  logic rise, fall, cs_s, mosi_s, frame;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              got_bit_q, got_bit_d, done_q, done_d;
  logic [REG_W-1:0]  sh_q, sh_d, tx_q, tx_d, rbuf_q, rbuf_d;
  logic              cmd_wr_q, cmd_wr_d, pf_q, pf_d, pend_q, pend_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d, addr_q, addr_d, issue_addr;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic              miso_q, miso_d, oe_q, oe_d, wr_rdn_q, wr_rdn_d;
  logic [REG_W-1:0]  wdata_q, wdata_d, rx_byte, acc_data;
  logic              req_q, req_d, we_q, we_d, xerr_q, xerr_d;
  logic              issue, issue_wr, last_bit, acc_ok, acc_bad, acc_done;

  spi_sync #(.STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk    (clk),
    .rst    (rst),
    .d_i    (spi_sclk),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Level-only synchronisers; cs_n resets to the idle (high) level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
    end
  end

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];
  assign frame  = ena & ~cs_s;

  assign acc_ok   = pend_q & ack & ~err;
  assign acc_bad  = pend_q & ((ack & err) | (~ack & (tmr_q == TMR_W'(ACK_TIMEOUT - 1))));
  assign acc_done = acc_ok | acc_bad;
  assign acc_data = acc_ok ? rdata : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      got_bit_q  <= 1'b0;
      done_q     <= 1'b0;
      sh_q       <= '0;
      tx_q       <= '0;
      rbuf_q     <= '0;
      cmd_wr_q   <= 1'b0;
      cmd_addr_q <= '0;
      pf_q       <= 1'b0;
      pend_q     <= 1'b0;
      tmr_q      <= '0;
      miso_q     <= 1'b0;
      oe_q       <= 1'b0;
      wr_rdn_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      xerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      got_bit_q  <= got_bit_d;
      done_q     <= done_d;
      sh_q       <= sh_d;
      tx_q       <= tx_d;
      rbuf_q     <= rbuf_d;
      cmd_wr_q   <= cmd_wr_d;
      cmd_addr_q <= cmd_addr_d;
      pf_q       <= pf_d;
      pend_q     <= pend_d;
      tmr_q      <= tmr_d;
      miso_q     <= miso_d;
      oe_q       <= oe_d;
      wr_rdn_q   <= wr_rdn_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      req_q      <= req_d;
      we_q       <= we_d;
      xerr_q     <= xerr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    got_bit_d  = got_bit_q;
    done_d     = done_q;
    sh_d       = sh_q;
    tx_d       = tx_q;
    rbuf_d     = rbuf_q;
    cmd_wr_d   = cmd_wr_q;
    cmd_addr_d = cmd_addr_q;
    pf_d       = pf_q;
    pend_d     = pend_q;
    tmr_d      = tmr_q;
    miso_d     = miso_q;
    oe_d       = frame;
    wr_rdn_d   = wr_rdn_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    req_d      = 1'b0;
    we_d       = 1'b0;
    xerr_d     = 1'b0;
    issue      = 1'b0;
    issue_wr   = 1'b0;
    issue_addr = cmd_addr_q;
    rx_byte    = {sh_q[REG_W-2:0], mosi_s};
    last_bit   = (cnt_q == CNT_W'(BYTE_W - 1));

    // Outstanding access: completes on ack or after ACK_TIMEOUT cycles
    if (pend_q) begin
      tmr_d = tmr_q + TMR_W'(1);
      if (acc_done) begin
        pend_d = 1'b0;
        rbuf_d = acc_data;
        xerr_d = acc_bad;
      end
    end

    if (state_q != S_IDLE && !frame) begin
      state_d = S_IDLE;
      miso_d  = 1'b0;
      pf_d    = 1'b0;
      pend_d  = 1'b0;
      if (got_bit_q && !(done_q && cnt_q == '0)) xerr_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame) begin
            state_d   = S_CMD;
            cnt_d     = '0;
            got_bit_d = 1'b0;
            done_d    = 1'b0;
            sh_d      = '0;
          end
        end
        S_CMD: begin
          if (rise) begin
            got_bit_d = 1'b1;
            sh_d      = rx_byte;
            cnt_d     = cnt_q + CNT_W'(1);
            if (last_bit) begin
              cmd_wr_d   = rx_byte[CMD_WR_BIT];
              cmd_addr_d = rx_byte[ADDR_W-1:0];
              if (rx_byte[CMD_WR_BIT]) begin
                state_d = S_DATA;
              end else begin
                issue      = 1'b1;
                issue_addr = rx_byte[ADDR_W-1:0];
                state_d    = S_ACC;
              end
            end
          end
        end
        S_DATA: begin
          if (cmd_wr_q) begin
            if (rise) begin
              got_bit_d = 1'b1;
              sh_d      = rx_byte;
              cnt_d     = cnt_q + CNT_W'(1);
              if (last_bit) begin
                done_d   = 1'b1;
                issue    = 1'b1;
                issue_wr = 1'b1;
                state_d  = S_ACC;
              end
            end
          end else begin
            if (AUTOINC && pf_q && !pend_q) begin
              issue = 1'b1;
              pf_d  = 1'b0;
            end
            if (fall) begin
              miso_d = tx_q[REG_W-1];
              tx_d   = tx_q << 1;
            end
            if (rise) begin
              got_bit_d = 1'b1;
              cnt_d     = cnt_q + CNT_W'(1);
              if (last_bit) begin
                done_d = 1'b1;
                if (AUTOINC) begin
                  // Next byte comes from the prefetch buffer; an unanswered prefetch reads as zero
                  if (pend_q && !acc_done) begin
                    tx_d   = '0;
                    pend_d = 1'b0;
                    xerr_d = 1'b1;
                  end else if (acc_done) begin
                    tx_d = acc_data;
                  end else begin
                    tx_d = rbuf_q;
                  end
                  cmd_addr_d = cmd_addr_q + ADDR_W'(1);
                  pf_d       = 1'b1;
                end else begin
                  state_d = S_DONE;
                  miso_d  = 1'b0;
                end
              end
            end
          end
        end
        S_ACC: begin
          if (cmd_wr_q) begin
            if (acc_done) begin
              if (AUTOINC) begin
                state_d    = S_DATA;
                cmd_addr_d = cmd_addr_q + ADDR_W'(1);
              end else begin
                state_d = S_DONE;
              end
            end
          end else if (acc_done || fall) begin
            // A falling edge before the ack forces the byte to zero
            state_d = S_DATA;
            tx_d    = acc_done ? acc_data : '0;
            if (fall) begin
              miso_d = tx_d[REG_W-1];
              tx_d   = tx_d << 1;
            end
            if (!acc_done) begin
              pend_d = 1'b0;
              xerr_d = 1'b1;
            end
            if (AUTOINC) begin
              cmd_addr_d = cmd_addr_q + ADDR_W'(1);
              pf_d       = 1'b1;
            end
          end
        end
        S_DONE: begin
          miso_d = 1'b0;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    if (issue) begin
      req_d    = 1'b1;
      we_d     = issue_wr;
      wr_rdn_d = issue_wr;
      addr_d   = issue_addr;
      pend_d   = 1'b1;
      tmr_d    = '0;
      if (issue_wr) wdata_d = rx_byte;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = oe_q;
  assign wr_rdn      = wr_rdn_q;
  assign addr        = addr_q;
  assign wdata       = wdata_q;
  assign req         = req_q;
  assign we          = we_q;
  assign xfer_err    = xerr_q;

endmodule

// File: tb/tb_spi_reg_initiator.sv
// Directed bench for spi_reg_initiator: table of single-access frames plus abort/reset/burst sequences.
module tb_spi_reg_initiator;

`ifdef SPI_REG_AUTOINC_EN
  localparam int AI = 1;
`else
  localparam int AI = 0;
`endif
  localparam int HALF = 8;

  logic       clk, rst, ena, spi_cs_n, spi_sclk, spi_mosi;
  logic       spi_miso, spi_miso_oe, wr_rdn, req, we, ack, err, xfer_err;
  logic [6:0] addr;
  logic [7:0] wdata, rdata;
  logic       ack_en, err_en;
  logic [7:0] rd_val;

  int total = 0;
  int bad = 0;
  int req_cnt = 0, we_cnt = 0, xerr_cnt = 0, viol_cnt = 0;
  logic [6:0] we_addr_log [64];
  logic [7:0] we_data_log [64];

  spi_reg_initiator dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .spi_cs_n    (spi_cs_n),
    .spi_sclk    (spi_sclk),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .wr_rdn      (wr_rdn),
    .addr        (addr),
    .wdata       (wdata),
    .req         (req),
    .we          (we),
    .rdata       (rdata),
    .ack         (ack),
    .err         (err),
    .xfer_err    (xfer_err)
  );

  // Register bank model: answers in the req cycle when enabled
  assign ack   = ack_en & req;
  assign err   = err_en & req;
  assign rdata = rd_val;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (req === 1'b1) req_cnt++;
    if (we === 1'b1) begin
      if (we_cnt < 64) begin
        we_addr_log[we_cnt] = addr;
        we_data_log[we_cnt] = wdata;
      end
      we_cnt++;
    end
    if (xfer_err === 1'b1) xerr_cnt++;
    if (we !== (req & wr_rdn)) viol_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Clock out nbits MSB-first from data[23:...]; capture MISO on rises 9..16
  task automatic spi_bits(input logic [23:0] data, input int nbits, output logic [7:0] miso_b);
    logic [7:0] mb;
    mb = '0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = data[23-i];
      tick(HALF);
      spi_sclk = 1'b1;
      if (i >= 8 && i < 16) mb = {mb[6:0], spi_miso};
      tick(HALF);
      spi_sclk = 1'b0;
    end
    miso_b = mb;
  endtask

  task automatic spi_frame(input logic [23:0] data, input int nbits,
                           output logic [7:0] miso_b, output logic oe_mid);
    spi_sclk = 1'b0;
    spi_cs_n = 1'b0;
    tick(HALF);
    oe_mid = spi_miso_oe;
    spi_bits(data, nbits, miso_b);
    tick(HALF);
    spi_cs_n = 1'b1;
    tick(4 * HALF);
  endtask

  typedef struct {
    logic [7:0] cmd;
    logic [7:0] dat;
    logic       ack_en;
    logic       err_en;
    logic [7:0] rd;
    int         exp_req;
    int         exp_we;
    int         exp_xerr;
    logic [6:0] exp_addr;
    logic [7:0] exp_wdata;
    logic [7:0] exp_miso;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int r0, w0, x0;
    logic [7:0] mb;
    logic oem;

    // Burst reads issue the initial access plus a prefetch after each loaded byte
    vecs[0] = '{8'h85, 8'h3C, 1'b1, 1'b0, 8'h00, 1,        1, 0,        7'h05,           8'h3C, 8'h00};
    vecs[1] = '{8'h05, 8'h00, 1'b1, 1'b0, 8'h3C, 1 + 2*AI, 0, 0,        7'(7'h05 + 2*AI), 8'h3C, 8'h3C};
    vecs[2] = '{8'h12, 8'h00, 1'b0, 1'b0, 8'hAA, 1 + 2*AI, 0, 1 + 2*AI, 7'(7'h12 + 2*AI), 8'h3C, 8'h00};
    vecs[3] = '{8'h7F, 8'h00, 1'b1, 1'b1, 8'h55, 1 + 2*AI, 0, 1 + 2*AI, 7'(7'h7F + 2*AI), 8'h3C, 8'h00};
    vecs[4] = '{8'hFF, 8'h5A, 1'b1, 1'b0, 8'h00, 1,        1, 0,        7'h7F,           8'h5A, 8'h00};
    vecs[5] = '{8'h2A, 8'h00, 1'b1, 1'b0, 8'hA5, 1 + 2*AI, 0, 0,        7'(7'h2A + 2*AI), 8'h5A, 8'hA5};
    vecs[6] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h00, 1,        1, 0,        7'h00,           8'h01, 8'h00};

    rst = 1'b0; ena = 1'b1; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    ack_en = 1'b0; err_en = 1'b0; rd_val = 8'h00;
    #2 rst = 1'b1;
    #1;
    check("reset_outputs", 32'({spi_miso, spi_miso_oe, wr_rdn, addr, wdata, req, we, xfer_err}), 32'd0);
    tick(3);
    rst = 1'b0;
    tick(4 * HALF);

    for (int i = 0; i < 7; i++) begin
      ack_en = vecs[i].ack_en;
      err_en = vecs[i].err_en;
      rd_val = vecs[i].rd;
      r0 = req_cnt; w0 = we_cnt; x0 = xerr_cnt;
      spi_frame({vecs[i].cmd, vecs[i].dat, 8'h00}, 16, mb, oem);
      check($sformatf("v%0d_req", i),    32'(req_cnt - r0),  32'(vecs[i].exp_req));
      check($sformatf("v%0d_we", i),     32'(we_cnt - w0),   32'(vecs[i].exp_we));
      check($sformatf("v%0d_xerr", i),   32'(xerr_cnt - x0), 32'(vecs[i].exp_xerr));
      check($sformatf("v%0d_addr", i),   32'(addr),          32'(vecs[i].exp_addr));
      check($sformatf("v%0d_wr_rdn", i), 32'(wr_rdn),        32'(vecs[i].cmd[7]));
      check($sformatf("v%0d_wdata", i),  32'(wdata),         32'(vecs[i].exp_wdata));
      check($sformatf("v%0d_miso", i),   32'(mb),            32'(vecs[i].exp_miso));
      check($sformatf("v%0d_oe_mid", i), 32'(oem),           32'd1);
      check($sformatf("v%0d_idle", i),   32'({spi_miso_oe, spi_miso}), 32'd0);
    end

    // Write aborted after 12 bits: nothing issued, one error pulse
    ack_en = 1'b1; err_en = 1'b0;
    r0 = req_cnt; x0 = xerr_cnt;
    spi_frame({8'h85, 8'h3C, 8'h00}, 12, mb, oem);
    check("abort12_req",  32'(req_cnt - r0),  32'd0);
    check("abort12_xerr", 32'(xerr_cnt - x0), 32'd1);
    check("abort12_oe",   32'(spi_miso_oe),   32'd0);

    // CS pulse with no clocks is silent
    x0 = xerr_cnt;
    spi_frame(24'h0, 0, mb, oem);
    check("empty_cs_xerr", 32'(xerr_cnt - x0), 32'd0);

    // Disabled block ignores a complete frame
    ena = 1'b0;
    r0 = req_cnt; x0 = xerr_cnt;
    spi_frame({8'h85, 8'h11, 8'h00}, 16, mb, oem);
    check("ena_off_req",  32'(req_cnt - r0),  32'd0);
    check("ena_off_xerr", 32'(xerr_cnt - x0), 32'd0);
    check("ena_off_oe",   32'(oem),           32'd0);
    ena = 1'b1;

    // Reset in the middle of a read data phase
    rd_val = 8'hFF;
    spi_cs_n = 1'b0;
    tick(HALF);
    spi_bits({8'h05, 8'h00, 8'h00}, 9, mb);
    tick(2);
    check("pre_rst_active", 32'({spi_miso_oe, spi_miso, addr}), 32'({1'b1, 1'b1, 7'(7'h05 + AI)}));
    rst = 1'b1;
    #1;
    check("mid_rst_outputs", 32'({spi_miso, spi_miso_oe, wr_rdn, addr, wdata, req, we, xfer_err}), 32'd0);
    tick(2);
    spi_cs_n = 1'b1;
    rst = 1'b0;
    tick(4 * HALF);
    w0 = we_cnt; x0 = xerr_cnt;
    spi_frame({8'h83, 8'h77, 8'h00}, 16, mb, oem);
    check("post_rst_we",    32'(we_cnt - w0),    32'd1);
    check("post_rst_xerr",  32'(xerr_cnt - x0),  32'd0);
    check("post_rst_addr",  32'(addr),           32'h03);
    check("post_rst_wdata", 32'(wdata),          32'h77);

    // Three-byte write starting at the top address
    w0 = we_cnt; x0 = xerr_cnt;
    spi_frame({8'hFF, 8'hAA, 8'hBB}, 24, mb, oem);
    check("burst_we_cnt", 32'(we_cnt - w0),   32'(1 + AI));
    check("burst_xerr",   32'(xerr_cnt - x0), 32'd0);
    check("burst_a0",     32'(we_addr_log[w0]), 32'h7F);
    check("burst_d0",     32'(we_data_log[w0]), 32'hAA);
`ifdef SPI_REG_AUTOINC_EN
    check("burst_a1",     32'(we_addr_log[w0+1]), 32'h00);
    check("burst_d1",     32'(we_data_log[w0+1]), 32'hBB);
`endif

    check("we_eq_req_and_wr", 32'(viol_cnt), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
